// File: rtl/pcu_multiway.sv
// pcu_multiway: multi-way fetch-address generator.
// Issues one aligned fetch group (WAYS instructions) per cycle, keeps the
// in-flight addresses in a small FIFO and, on a redirect, flushes the FIFO
// and discards the matching number of late bus responses.
// Optional macro PCU_PERF_CNT_EN adds issue/flush/stall counters.
module pcu_multiway #(
    parameter int                ADDR_W          = 32,
    parameter int                WAYS            = 2,
    parameter int                MAX_OUTSTANDING = 4,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready_i,
    input  logic              dataOk_i,
    input  logic              jumpFlag_i,
    input  logic [ADDR_W-1:0] jumpAddr_i,
    output logic              request_o,
    output logic [ADDR_W-1:0] reqAddr_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] instAddr_o,
    output logic [WAYS-1:0]   wayMask_o
`ifdef PCU_PERF_CNT_EN
    ,
    output logic [31:0]       issueCnt_o,
    output logic [31:0]       flushCnt_o,
    output logic [31:0]       stallCnt_o
`endif
);

    localparam int GRP_B = WAYS * 4;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    MAX_V    = (CNT_W+1)'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] GRP_V    = ADDR_W'(GRP_B);
    localparam logic [ADDR_W-1:0] GRP_MASK = ~(ADDR_W'(GRP_B - 1));

    // Address/mask FIFO storage and pointers
    logic [ADDR_W-1:0] fifo_addr_q [MAX_OUTSTANDING];
    logic [WAYS-1:0]   fifo_mask_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, drop_q, drop_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              request_q, request_d, valid_q, valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d, inst_addr_q, inst_addr_d;
    logic [WAYS-1:0]   way_mask_q, way_mask_d;

    logic [CNT_W:0]    inflight;
    logic              resp_act, can_issue, pop, drop_resp;
    logic [WAYS-1:0]   issue_mask;

    assign inflight  = {1'b0, cnt_q} + {1'b0, drop_q};
    assign resp_act  = dataOk_i & (inflight != '0);
    assign can_issue = ready_i & ~jumpFlag_i & (inflight < MAX_V);
    // A response either retires the FIFO head or burns a flushed slot.
    assign pop       = resp_act & ~jumpFlag_i & (drop_q == '0);
    assign drop_resp = resp_act & ~pop;

    // Slots below the PC's offset inside its group are not usable.
    generate
        if (WAYS == 1) begin : g_mask_one
            assign issue_mask = 1'b1;
        end else begin : g_mask_multi
            logic [$clog2(WAYS)-1:0] off;
            assign off        = pc_q[$clog2(WAYS)+1:2];
            assign issue_mask = ~((WAYS'(1) << off) - WAYS'(1));
        end
    endgenerate

    // Next-state for PC, FIFO bookkeeping, drop counter and outputs
    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        request_d   = can_issue;
        req_addr_d  = req_addr_q;
        valid_d     = 1'b0;
        inst_addr_d = inst_addr_q;
        way_mask_d  = way_mask_q;

        if (can_issue) begin
            req_addr_d = pc_q;
        end

        if (jumpFlag_i) begin
            // Everything in the FIFO becomes stale; a same-cycle response
            // already consumes one of those stale slots.
            pc_d     = {jumpAddr_i[ADDR_W-1:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            drop_d   = drop_q + cnt_q - CNT_W'(resp_act);
        end else begin
            if (can_issue) begin
                pc_d     = (pc_q & GRP_MASK) + GRP_V;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (drop_resp) begin
                drop_d = drop_q - 1'b1;
            end
            if (pop) begin
                valid_d     = 1'b1;
                inst_addr_d = fifo_addr_q[rd_ptr_q];
                way_mask_d  = fifo_mask_q[rd_ptr_q];
                rd_ptr_d    = rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(can_issue) - CNT_W'(pop);
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            drop_q      <= '0;
            request_q   <= 1'b0;
            req_addr_q  <= '0;
            valid_q     <= 1'b0;
            inst_addr_q <= '0;
            way_mask_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            request_q   <= request_d;
            req_addr_q  <= req_addr_d;
            valid_q     <= valid_d;
            inst_addr_q <= inst_addr_d;
            way_mask_q  <= way_mask_d;
        end
    end

    // FIFO payload write; contents are only meaningful under cnt_q
    always_ff @(posedge clk) begin
        if (can_issue) begin
            fifo_addr_q[wr_ptr_q] <= pc_q;
            fifo_mask_q[wr_ptr_q] <= issue_mask;
        end
    end

    assign request_o  = request_q;
    assign reqAddr_o  = req_addr_q;
    assign valid_o    = valid_q;
    assign instAddr_o = inst_addr_q;
    assign wayMask_o  = way_mask_q;

`ifdef PCU_PERF_CNT_EN
    logic [31:0] issue_cnt_q, flush_cnt_q, stall_cnt_q;
    logic        stall;

    assign stall = ready_i & ~jumpFlag_i & (inflight == MAX_V);

    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_q + 32'(can_issue);
            flush_cnt_q <= flush_cnt_q + 32'(drop_resp);
            stall_cnt_q <= stall_cnt_q + 32'(stall);
        end
    end

    assign issueCnt_o = issue_cnt_q;
    assign flushCnt_o = flush_cnt_q;
    assign stallCnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pcu_multiway.sv
// Scoreboard bench for pcu_multiway (ADDR_W=32, WAYS=2, MAX_OUTSTANDING=4).
module tb_pcu_multiway;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  mask;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready_i = 1'b0, dataOk_i = 1'b0, jumpFlag_i = 1'b0;
    logic [31:0] jumpAddr_i = '0;
    logic        request_o, valid_o;
    logic [31:0] reqAddr_o, instAddr_o;
    logic [1:0]  wayMask_o;
`ifdef PCU_PERF_CNT_EN
    logic [31:0] issueCnt_o, flushCnt_o, stallCnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_req[$];
    rsp_t        exp_rsp[$];

    pcu_multiway #(.ADDR_W(32), .WAYS(2), .MAX_OUTSTANDING(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .ready_i(ready_i), .dataOk_i(dataOk_i),
        .jumpFlag_i(jumpFlag_i), .jumpAddr_i(jumpAddr_i),
        .request_o(request_o), .reqAddr_o(reqAddr_o), .valid_o(valid_o),
        .instAddr_o(instAddr_o), .wayMask_o(wayMask_o)
`ifdef PCU_PERF_CNT_EN
        , .issueCnt_o(issueCnt_o), .flushCnt_o(flushCnt_o), .stallCnt_o(stallCnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every presented request/response is popped and compared
    always @(negedge clk) begin
        if (!reset) begin
            if (request_o) begin
                n_tests++;
                if (exp_req.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_unexpected: got reqAddr_o=%h, expected no request", reqAddr_o);
                end else begin
                    logic [31:0] e;
                    e = exp_req.pop_front();
                    if (reqAddr_o !== e) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, expected %h", reqAddr_o, e);
                    end
                end
            end
            if (valid_o) begin
                n_tests++;
                if (exp_rsp.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got instAddr_o=%h wayMask_o=%b, expected no valid",
                             instAddr_o, wayMask_o);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    if (instAddr_o !== r.addr || wayMask_o !== r.mask) begin
                        n_fail++;
                        $display("FAIL rsp: got %h/%b, expected %h/%b", instAddr_o, wayMask_o, r.addr, r.mask);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drained(input string nm);
        @(negedge clk);
        #1;
        chk({nm, "_req_left"}, 32'(exp_req.size()), 32'd0);
        chk({nm, "_rsp_left"}, 32'(exp_rsp.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_request"}, 32'(request_o), 32'd0);
        chk({nm, "_valid"},   32'(valid_o),   32'd0);
        chk({nm, "_reqAddr"}, reqAddr_o,      32'd0);
        chk({nm, "_instAddr"}, instAddr_o,    32'd0);
        chk({nm, "_wayMask"}, 32'(wayMask_o), 32'd0);
`ifdef PCU_PERF_CNT_EN
        chk({nm, "_issueCnt"}, issueCnt_o, 32'd0);
        chk({nm, "_flushCnt"}, flushCnt_o, 32'd0);
        chk({nm, "_stallCnt"}, stallCnt_o, 32'd0);
`endif
    endtask

    initial begin
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;

        // Startup: four issues from RESET_PC, then stall with no responses
        exp_req.push_back(32'h00); exp_req.push_back(32'h08);
        exp_req.push_back(32'h10); exp_req.push_back(32'h18);
        reset   = 1'b0;
        ready_i = 1'b1;
        repeat (8) step();
        drained("startup");

        // Steady stream: one response per cycle, in-order groups
        for (int i = 0; i < 6; i++) exp_rsp.push_back('{addr: 32'(i * 8), mask: 2'b11});
        for (int i = 0; i < 5; i++) exp_req.push_back(32'h20 + 32'(i * 8));
        dataOk_i = 1'b1;
        repeat (6) step();

        // Redirect with three in flight; target low bits must be ignored
        exp_req.push_back(32'h104); exp_req.push_back(32'h108);
        exp_req.push_back(32'h110); exp_req.push_back(32'h118);
        exp_req.push_back(32'h120);
        exp_rsp.push_back('{addr: 32'h104, mask: 2'b10});
        dataOk_i   = 1'b0;
        jumpFlag_i = 1'b1;
        jumpAddr_i = 32'h106;
        step();
        jumpFlag_i = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            dataOk_i = 1'b1; step();
            dataOk_i = 1'b0; step();
        end
        drained("redirect");

        // Jump together with a response, cnt=2; target near top for PC wrap
        exp_rsp.push_back('{addr: 32'h108, mask: 2'b11});
        exp_rsp.push_back('{addr: 32'h110, mask: 2'b11});
        ready_i  = 1'b0;
        dataOk_i = 1'b1;
        step();
        step();
        jumpFlag_i = 1'b1;
        jumpAddr_i = 32'hFFFF_FFF8;
        step();
        jumpFlag_i = 1'b0;
        dataOk_i   = 1'b0;
        ready_i    = 1'b1;
        exp_req.push_back(32'hFFFF_FFF8); exp_req.push_back(32'h0);
        exp_req.push_back(32'h8);         exp_req.push_back(32'h10);
        exp_req.push_back(32'h18);
        exp_rsp.push_back('{addr: 32'hFFFF_FFF8, mask: 2'b11});
        repeat (4) step();
        dataOk_i = 1'b1; step();
        dataOk_i = 1'b0; step();
        dataOk_i = 1'b1; step();
        dataOk_i = 1'b0; step();
        drained("jump_same_cycle");

        // Async reset mid-stream with two outstanding
        exp_rsp.push_back('{addr: 32'h0, mask: 2'b11});
        exp_rsp.push_back('{addr: 32'h8, mask: 2'b11});
        ready_i  = 1'b0;
        dataOk_i = 1'b1;
        step();
        step();
        dataOk_i = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        chk("async_reset_rsp_left", 32'(exp_rsp.size()), 32'd0);

        // Stale responses after release must be ignored; issue restarts at RESET_PC
        dataOk_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        step();
        dataOk_i = 1'b0;
        ready_i  = 1'b1;
        exp_req.push_back(32'h00); exp_req.push_back(32'h08);
        exp_req.push_back(32'h10); exp_req.push_back(32'h18);
        repeat (8) step();
        drained("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
